// File: rtl/emu_clk_div_ctrl.sv
// Glitch-safe sequencer for one emulation clock divider: gate, load ratio, settle, re-enable.
// Optional build macro EMU_CLK_DIV_CTRL_RATIO_CHECK_EN restricts ratios to the supported set.
module emu_clk_div_ctrl #(
   parameter int unsigned GATE_CYCLES   = 4,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter logic [31:0] RESET_NUM     = 32'd1,
   parameter logic [31:0] RESET_DEN     = 32'd50
) (
   input  logic        input_clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_enable,
   input  logic [31:0] req_num,
   input  logic [31:0] req_den,
   output logic        div_enable,
   output logic [31:0] div_num,
   output logic [31:0] div_den,
   output logic        locked,
   output logic        busy,
   output logic        done,
   output logic        done_err
);

   typedef enum logic [2:0] {IDLE, CHECK, GATE, LOAD, SETTLE, DONE} state_t;

   state_t      state, state_next;
   logic [7:0]  cnt;
   logic        cap_en;
   logic [31:0] cap_num, cap_den;
   logic        ratio_ok, req_ok, noop;

`ifdef EMU_CLK_DIV_CTRL_RATIO_CHECK_EN
   assign ratio_ok = (cap_num == 32'd1) &&
                     (cap_den inside {32'd14, 32'd20, 32'd25, 32'd40, 32'd42, 32'd50});
`else
   assign ratio_ok = 1'b1;
`endif

   // A disable request carries no ratio, so it can never be rejected.
   assign req_ok = !cap_en ||
                   ((cap_num != 32'd0) && (cap_den != 32'd0) && (cap_num <= cap_den) && ratio_ok);
   assign noop   = (cap_en && div_enable && (cap_num == div_num) && (cap_den == div_den)) ||
                   (!cap_en && !div_enable);

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge input_clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_valid) state_next = CHECK;
         CHECK:   state_next = (!req_ok || noop) ? DONE : GATE;
         GATE:    if (cnt == 8'd0) state_next = LOAD;
         LOAD:    state_next = cap_en ? SETTLE : DONE;
         SETTLE:  if (cnt == 8'd0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge input_clk or posedge reset) begin
      if (reset) begin
         cnt        <= 8'd0;
         cap_en     <= 1'b0;
         cap_num    <= 32'd0;
         cap_den    <= 32'd0;
         div_enable <= 1'b0;
         div_num    <= RESET_NUM;
         div_den    <= RESET_DEN;
         locked     <= 1'b0;
         done       <= 1'b0;
         done_err   <= 1'b0;
      end else begin
         done     <= (state != DONE) && (state_next == DONE);
         done_err <= (state == CHECK) && !req_ok;
         case (state)
            IDLE: if (req_valid) begin
               cap_en  <= req_enable;
               cap_num <= req_num;
               cap_den <= req_den;
            end
            CHECK: if (req_ok && !noop) begin
               div_enable <= 1'b0;
               locked     <= 1'b0;
               cnt        <= 8'(GATE_CYCLES - 1);
            end
            GATE: if (cnt != 8'd0) cnt <= cnt - 8'd1;
            // Divider is gated here, so the ratio can change without a glitch.
            LOAD: if (cap_en) begin
               div_num <= cap_num;
               div_den <= cap_den;
               cnt     <= 8'(SETTLE_CYCLES - 1);
            end
            SETTLE: begin
               if (cnt == 8'd0) begin
                  div_enable <= 1'b1;
                  locked     <= 1'b1;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_emu_clk_div_ctrl.sv
// Scoreboard bench for emu_clk_div_ctrl: stimulus queues expected completions, monitor checks them.
module tb_emu_clk_div_ctrl;

   logic        input_clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, req_enable = 1'b0;
   logic [31:0] req_num = '0, req_den = '0;
   logic        req_ready, div_enable, locked, busy, done, done_err;
   logic [31:0] div_num, div_den;

   emu_clk_div_ctrl dut (
      .input_clk (input_clk), .reset (reset),
      .req_valid (req_valid), .req_ready (req_ready), .req_enable (req_enable),
      .req_num   (req_num),   .req_den   (req_den),
      .div_enable(div_enable), .div_num  (div_num),   .div_den   (div_den),
      .locked    (locked),    .busy      (busy),      .done      (done),
      .done_err  (done_err)
   );

   always #5 input_clk = ~input_clk;

   typedef struct {
      logic        err, en, lock;
      logic [31:0] num, den;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   cyc = 0;
   int   total = 0, bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", name, act, exp);
      end
   endtask

   // Edge counter and accept-edge recorder; a reset discards any in-flight request.
   always @(posedge input_clk or posedge reset) begin
      if (reset) acc_q.delete();
      else begin
         cyc++;
         if (req_valid && req_ready) acc_q.push_back(cyc);
      end
   end

   always @(negedge input_clk) begin
      if (!reset && done) begin
         if (exp_q.size() == 0 || acc_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            int   k;
            e = exp_q.pop_front();
            k = acc_q.pop_front();
            chk("done_latency", 32'(cyc - k + 1), 32'(e.lat));
            chk("done_err",     32'(done_err),   32'(e.err));
            chk("div_enable",   32'(div_enable), 32'(e.en));
            chk("locked",       32'(locked),     32'(e.lock));
            chk("div_num",      div_num,         e.num);
            chk("div_den",      div_den,         e.den);
         end
      end
   end

   task automatic expect_done(input logic err, en, lock, input logic [31:0] num, den, input int lat);
      exp_t e;
      e.err = err; e.en = en; e.lock = lock; e.num = num; e.den = den; e.lat = lat;
      exp_q.push_back(e);
   endtask

   // Returns just after the accepting edge (edge k); the next negedge is cycle k+1.
   task automatic issue(input logic en, input logic [31:0] num, den, input bit hold);
      int n = 0;
      @(negedge input_clk);
      req_valid = 1'b1; req_enable = en; req_num = num; req_den = den;
      while (!req_ready && n < 50) begin @(negedge input_clk); n++; end
      if (n >= 50) begin
         $display("FAIL accept_timeout: got=0 want=1");
         $fatal(1, "accept timeout");
      end
      @(posedge input_clk);
      #1 if (!hold) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || !req_ready) && n < 60) begin @(negedge input_clk); n++; end
      if (n >= 60) chk("idle_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   logic [31:0] cur_den;
   int          drops, waits;

   initial begin
      repeat (3) @(negedge input_clk);
      reset = 1'b0;
      repeat (5) @(negedge input_clk);
      chk("rst_div_enable", 32'(div_enable), 32'd0);
      chk("rst_div_num",    div_num,         32'd1);
      chk("rst_div_den",    div_den,         32'd50);
      chk("rst_req_ready",  32'(req_ready),  32'd1);
      chk("rst_locked",     32'(locked),     32'd0);
      chk("rst_done",       32'(done),       32'd0);
      chk("rst_busy",       32'(busy),       32'd0);

      // Full change to 1/20 with cycle-exact checkpoints.
      expect_done(1'b0, 1'b1, 1'b1, 32'd1, 32'd20, 15);
      issue(1'b1, 32'd1, 32'd20, 1'b0);
      repeat (2) @(negedge input_clk);
      chk("k2_div_enable", 32'(div_enable), 32'd0);
      chk("k2_busy",       32'(busy),       32'd1);
      chk("k2_req_ready",  32'(req_ready),  32'd0);
      repeat (5) @(negedge input_clk);
      chk("k7_div_den",    div_den,         32'd20);
      chk("k7_div_enable", 32'(div_enable), 32'd0);
      repeat (7) @(negedge input_clk);
      chk("k14_div_enable", 32'(div_enable), 32'd0);
      @(negedge input_clk);
      chk("k15_div_enable", 32'(div_enable), 32'd1);
      chk("k15_locked",     32'(locked),     32'd1);
      wait_idle();

      // Same ratio while locked: no-op, divider never gated.
      expect_done(1'b0, 1'b1, 1'b1, 32'd1, 32'd20, 2);
      issue(1'b1, 32'd1, 32'd20, 1'b0);
      drops = 0;
      repeat (6) begin @(negedge input_clk); if (!div_enable) drops++; end
      chk("noop_drops", 32'(drops), 32'd0);
      wait_idle();

`ifdef EMU_CLK_DIV_CTRL_RATIO_CHECK_EN
      cur_den = 32'd20;
      expect_done(1'b1, 1'b1, 1'b1, 32'd1, cur_den, 2);
`else
      cur_den = 32'd33;
      expect_done(1'b0, 1'b1, 1'b1, 32'd1, cur_den, 15);
`endif
      issue(1'b1, 32'd1, 32'd33, 1'b0);
      wait_idle();

      expect_done(1'b1, 1'b1, 1'b1, 32'd1, cur_den, 2);
      issue(1'b1, 32'd0, 32'd50, 1'b0);
      wait_idle();
      expect_done(1'b1, 1'b1, 1'b1, 32'd1, cur_den, 2);
      issue(1'b1, 32'd60, 32'd50, 1'b0);
      wait_idle();

      // Reset in SETTLE of a 1/25 change aborts with no completion.
      issue(1'b1, 32'd1, 32'd25, 1'b0);
      repeat (10) @(negedge input_clk);
      chk("settle_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("abort_div_enable", 32'(div_enable), 32'd0);
      chk("abort_div_num",    div_num,         32'd1);
      chk("abort_div_den",    div_den,         32'd50);
      chk("abort_locked",     32'(locked),     32'd0);
      chk("abort_busy",       32'(busy),       32'd0);
      repeat (3) @(negedge input_clk);
      reset = 1'b0;
      repeat (20) @(negedge input_clk);
      chk("abort_no_done_pending", 32'(acc_q.size()), 32'd0);

      expect_done(1'b0, 1'b1, 1'b1, 32'd1, 32'd40, 15);
      issue(1'b1, 32'd1, 32'd40, 1'b0);
      wait_idle();

      // Disable while locked, valid held; the second request (1/50) waits for IDLE.
      expect_done(1'b0, 1'b0, 1'b0, 32'd1, 32'd40, 7);
      issue(1'b0, 32'd0, 32'd0, 1'b1);
      req_enable = 1'b1; req_num = 32'd1; req_den = 32'd50;
      expect_done(1'b0, 1'b1, 1'b1, 32'd1, 32'd50, 15);
      @(negedge input_clk);
      chk("dis_k1_div_enable", 32'(div_enable), 32'd1);
      @(negedge input_clk);
      chk("dis_k2_div_enable", 32'(div_enable), 32'd0);
      chk("dis_k2_locked",     32'(locked),     32'd0);
      waits = 2;
      while (!req_ready && waits < 40) begin @(negedge input_clk); waits++; end
      chk("held_ready_wait", 32'(waits), 32'd8);
      @(posedge input_clk);
      #1 req_valid = 1'b0;
      wait_idle();
      repeat (3) @(negedge input_clk);
      chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got=1 want=0");
      $fatal(1, "timeout");
   end

endmodule
